// File: rtl/uart_led_pkg.sv
// uart_led_pkg: shared constants and types for the UART LED command controller.
//   - Frame delimiter bytes (SOF 'L', EOF LF) and ACTION byte codes.
//   - fsm_state_t: frame parser state encoding.
//   - action_known(): tells whether an ACTION byte is a legal command code.
package uart_led_pkg;

  localparam logic [7:0] SOF_BYTE  = 8'h4C;  // 'L'
  localparam logic [7:0] EOF_BYTE  = 8'h0A;  // LF
  localparam logic [7:0] ACT_ON    = 8'h6E;  // 'n'
  localparam logic [7:0] ACT_OFF   = 8'h66;  // 'f'
  localparam logic [7:0] ACT_TOG   = 8'h74;  // 't'
  localparam logic [7:0] ACT_BLINK = 8'h62;  // 'b'

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_GET_IDX,
    ST_GET_ACT,
    ST_GET_EOF
  } fsm_state_t;

  // 'b' only counts as legal when the blink feature is built in.
  function automatic logic action_known(input logic [7:0] act, input logic blink_ok);
    return (act == ACT_ON) || (act == ACT_OFF) || (act == ACT_TOG) ||
           (blink_ok && (act == ACT_BLINK));
  endfunction

endpackage

// File: rtl/uart_led_cmd_ctrl_if.sv
// uart_led_cmd_ctrl_if: UART RX byte stream into the LED command controller.
//   rx_data  : received byte, meaningful only while rx_valid is high
//   rx_valid : single-cycle strobe, one byte per high cycle
// Modports: master (UART receiver side), slave (command controller side).
interface uart_led_cmd_ctrl_if;
  logic [7:0] rx_data;
  logic       rx_valid;

  modport master (output rx_data, output rx_valid);
  modport slave  (input  rx_data, input  rx_valid);
endinterface

// File: rtl/led_frame_timer.sv
// led_frame_timer: inter-byte timeout counter for the frame parser.
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : forces the count to zero (takes priority over enable)
//   enable     : counts one per cycle while high
//   expired    : high for the one cycle in which the count sits at TIMEOUT_CYC-1
//                while enabled and not cleared
module led_frame_timer #(
  parameter int unsigned TIMEOUT_CYC = 1000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] cnt_reg;

  // Expiry is suppressed by clear so a byte arriving on the last cycle wins.
  assign expired = enable && !clear && (cnt_reg == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else if (clear || expired) begin
      cnt_reg <= '0;
    end else if (enable) begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

endmodule

// File: rtl/uart_led_cmd_ctrl.sv
// uart_led_cmd_ctrl: parses 4-byte frames (SOF, INDEX, ACTION, EOF) from the
// UART RX byte stream and sets/clears/toggles one LED of a bank.
// Optional feature macro: LED_BLINK_EN (adds the 'b' blink action).
//   clk, rst_n : clock, asynchronous active-low reset
//   rx_bus     : uart_led_cmd_ctrl_if.slave (rx_data, rx_valid)
//   led        : registered LED outputs
//   cmd_done   : one-cycle pulse when a frame is executed
//   cmd_err    : one-cycle pulse when a frame is discarded (bad content or timeout)
module uart_led_cmd_ctrl
  import uart_led_pkg::*;
#(
  parameter int unsigned NUM_LEDS    = 10,
  parameter int unsigned TIMEOUT_CYC = 1000000,
  parameter int unsigned BLINK_HALF  = 25000000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  uart_led_cmd_ctrl_if.slave     rx_bus,
  output logic [NUM_LEDS-1:0]    led,
  output logic                   cmd_done,
  output logic                   cmd_err
);

  localparam int unsigned IDX_W = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
  localparam logic [8:0]  NUM_LEDS_W = 9'(NUM_LEDS);

  fsm_state_t          state_reg;
  logic [IDX_W-1:0]    idx_reg;
  logic [7:0]          act_reg;
  logic                bad_reg;
  logic [NUM_LEDS-1:0] led_reg;
  logic                done_reg;
  logic                err_reg;

  logic [NUM_LEDS-1:0] led_base;   // LED value after any blink wrap this cycle
  logic [NUM_LEDS-1:0] led_next;
  logic [NUM_LEDS-1:0] hit;        // one-hot: LED addressed by a frame executing now
  logic                exec_now;
  logic                timer_expired;

  // Timer is held clear in IDLE and restarted by every accepted byte.
  led_frame_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (rx_bus.rx_valid || (state_reg == ST_IDLE)),
    .enable  (state_reg != ST_IDLE),
    .expired (timer_expired)
  );

  assign exec_now = rx_bus.rx_valid && (state_reg == ST_GET_EOF) &&
                    (rx_bus.rx_data == EOF_BYTE) && !bad_reg;

`ifdef LED_BLINK_EN
  localparam logic BLINK_OK = 1'b1;
  localparam int unsigned BC_W = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam logic [BC_W-1:0] BLINK_LAST = BC_W'(BLINK_HALF - 1);

  logic [BC_W-1:0]     blink_cnt_reg;
  logic [NUM_LEDS-1:0] blink_reg;
  logic [NUM_LEDS-1:0] blink_next;
  logic                blink_wrap;

  // One free-running counter shared by every blinking LED.
  assign blink_wrap = (blink_cnt_reg == BLINK_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt_reg <= '0;
      blink_reg     <= '0;
    end else begin
      blink_cnt_reg <= blink_wrap ? '0 : blink_cnt_reg + 1'b1;
      blink_reg     <= blink_next;
    end
  end

  // Any executed action on an LED rewrites its flag: set only by 'b'.
  for (genvar gi = 0; gi < NUM_LEDS; gi++) begin : g_blink
    assign led_base[gi]   = led_reg[gi] ^ (blink_wrap & blink_reg[gi]);
    assign blink_next[gi] = hit[gi] ? (act_reg == ACT_BLINK) : blink_reg[gi];
  end
`else
  localparam logic BLINK_OK = 1'b0;
  assign led_base = led_reg;
`endif

  // Per-LED update; an action is applied on top of this cycle's blink wrap,
  // and 'b' itself leaves the value alone until the next wrap.
  for (genvar gi = 0; gi < NUM_LEDS; gi++) begin : g_led
    assign hit[gi] = exec_now && (idx_reg == IDX_W'(gi));
    assign led_next[gi] = !hit[gi]              ? led_base[gi] :
                          (act_reg == ACT_ON)   ? 1'b1 :
                          (act_reg == ACT_OFF)  ? 1'b0 :
                          (act_reg == ACT_TOG)  ? ~led_base[gi] :
                                                  led_base[gi];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      idx_reg   <= '0;
      act_reg   <= '0;
      bad_reg   <= 1'b0;
      led_reg   <= '0;
      done_reg  <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      err_reg  <= 1'b0;
      led_reg  <= led_next;
      if (rx_bus.rx_valid) begin
        case (state_reg)
          ST_IDLE: begin
            // Non-SOF bytes between frames are line noise: drop silently.
            if (rx_bus.rx_data == SOF_BYTE) begin
              state_reg <= ST_GET_IDX;
              bad_reg   <= 1'b0;
            end
          end
          ST_GET_IDX: begin
            idx_reg   <= rx_bus.rx_data[IDX_W-1:0];
            bad_reg   <= ({1'b0, rx_bus.rx_data} >= NUM_LEDS_W);
            state_reg <= ST_GET_ACT;
          end
          ST_GET_ACT: begin
            act_reg   <= rx_bus.rx_data;
            bad_reg   <= bad_reg || !action_known(rx_bus.rx_data, BLINK_OK);
            state_reg <= ST_GET_EOF;
          end
          default: begin
            // Fourth byte always ends the frame so the parser stays aligned.
            state_reg <= ST_IDLE;
            done_reg  <= exec_now;
            err_reg   <= !exec_now;
          end
        endcase
      end else if (timer_expired) begin
        state_reg <= ST_IDLE;
        err_reg   <= 1'b1;
      end
    end
  end

  assign led      = led_reg;
  assign cmd_done = done_reg;
  assign cmd_err  = err_reg;

endmodule
